noc_local_packetizer: RTL and testbench

- Network-interface injection stage between the tile compute/DMA side and the router local port (port index 4).
- Accepts one packet request (destination, payload length) plus a stream of payload words.
- Emits a head flit, then the payload flits, with the last payload flit tagged as tail, on a registered valid/ready flit interface.
- Sits directly upstream of the router's local input, one instance per tile.

---
 rtl/noc_local_packetizer.sv | 126 ++++++++++++
 tb/tb_noc_local_packetizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_packetizer.sv
// Local-port packetizer: request + payload words in, head/body/tail flits out with one cycle of latency.
// A single output register stalls in place while ready_in is low, and both inputs are backpressured until it can load.
module noc_local_packetizer #(
  parameter int FLIT_W  = 64,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 6,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [COORD_W-1:0]   req_dst_x,
  input  logic [COORD_W-1:0]   req_dst_y,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [FLIT_W-3:0]    data_in,
  output logic [FLIT_W-1:0]    flit_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 busy,
  output logic [15:0]          pkt_count
);

  localparam int PAD_W = FLIT_W - 2 - 4*COORD_W - LEN_W;

  localparam logic [1:0] TYP_BODY = 2'b00;
  localparam logic [1:0] TYP_HEAD = 2'b01;
  localparam logic [1:0] TYP_TAIL = 2'b10;
  localparam logic [1:0] TYP_HT   = 2'b11;

  typedef struct packed {
    logic [1:0]         typ;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;
    logic [LEN_W-1:0]   len;
    logic [PAD_W-1:0]   pad;
  } hdr_t;

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic               vld_q, vld_d;
  logic               load_en;
  hdr_t               hdr;

  // Gated by rst_n so neither input handshakes while reset is held.
  assign load_en = rst_n && (!vld_q || ready_in);

  always_comb begin
    hdr.typ   = (req_len == '0) ? TYP_HT : TYP_HEAD;
    hdr.dst_x = req_dst_x;
    hdr.dst_y = req_dst_y;
    hdr.src_x = COORD_W'(SRC_X);
    hdr.src_y = COORD_W'(SRC_Y);
    hdr.len   = req_len;
    hdr.pad   = '0;
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    flit_d     = flit_q;
    vld_d      = vld_q && !ready_in;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = load_en;
        if (req_valid && load_en) begin
          vld_d  = 1'b1;
          flit_d = hdr;
          if (req_len != '0) begin
            rem_d   = req_len;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        data_ready = load_en;
        if (data_valid && load_en) begin
          vld_d = 1'b1;
          // rem_q <= 1 rather than == 1 so a corrupted counter can never wrap.
          if (rem_q <= LEN_W'(1)) begin
            flit_d  = {TYP_TAIL, data_in};
            rem_d   = '0;
            state_d = IDLE;
          end else begin
            flit_d = {TYP_BODY, data_in};
            rem_d  = rem_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      flit_q    <= '0;
      vld_q     <= 1'b0;
      pkt_count <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      flit_q  <= flit_d;
      vld_q   <= vld_d;
      // Head and head+tail both have bit FLIT_W-2 set.
      if (vld_q && ready_in && flit_q[FLIT_W-2])
        pkt_count <= pkt_count + 16'd1;
    end
  end

  assign flit_out  = flit_q;
  assign valid_out = vld_q;
  assign busy      = (state_q != IDLE) || vld_q;

endmodule

// File: tb/tb_noc_local_packetizer.sv
// Directed bench for noc_local_packetizer with SRC=(1,1) and default widths.
module tb_noc_local_packetizer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dst_x;
  logic [3:0]  req_dst_y;
  logic [5:0]  req_len;
  logic        data_valid;
  logic        data_ready;
  logic [61:0] data_in;
  logic [63:0] flit_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  noc_local_packetizer #(
    .FLIT_W(64), .COORD_W(4), .LEN_W(6), .SRC_X(1), .SRC_Y(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy(busy), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] head(input logic [1:0] t, input logic [3:0] dx,
                                       input logic [3:0] dy, input logic [5:0] len);
    return {t, dx, dy, 4'd1, 4'd1, len, 40'd0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ready_in = 1'b1; req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0;
    req_len = '0; data_valid = 1'b0; data_in = '0;

    // Reset then idle
    step(); step();
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_flit", flit_out, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("idle_req_ready", 64'(req_ready), 64'd1);

    // Single-flit packet dst=(3,2) len=0
    req_valid = 1'b1; req_dst_x = 4'd3; req_dst_y = 4'd2; req_len = 6'd0;
    step();
    req_valid = 1'b0;
    #1;
    check("ht_valid", 64'(valid_out), 64'd1);
    check("ht_flit", flit_out, 64'hCC84_4000_0000_0000);
    check("ht_req_ready", 64'(req_ready), 64'd1);
    check("ht_cnt_before", 64'(pkt_count), 64'd0);
    step();
    check("ht_cnt_after", 64'(pkt_count), 64'd1);
    check("ht_drained", 64'(valid_out), 64'd0);

    // 3-beat packet at full rate; data_valid early must not be consumed in IDLE
    req_valid = 1'b1; req_dst_x = 4'd2; req_dst_y = 4'd1; req_len = 6'd3;
    data_valid = 1'b1; data_in = 62'h1;
    #1;
    check("idle_data_ready", 64'(data_ready), 64'd0);
    step();
    req_valid = 1'b0;
    #1;
    check("p3_head", flit_out, head(2'b01, 4'd2, 4'd1, 6'd3));
    check("p3_req_ready", 64'(req_ready), 64'd0);
    check("p3_data_ready", 64'(data_ready), 64'd1);
    step(); data_in = 62'h2; #1;
    check("p3_body1", flit_out, {2'b00, 62'h1});
    step(); data_in = 62'h3; #1;
    check("p3_body2", flit_out, {2'b00, 62'h2});
    step(); data_valid = 1'b0; #1;
    check("p3_tail", flit_out, {2'b10, 62'h3});
    check("p3_busy_tail", 64'(busy), 64'd1);
    step();
    check("p3_busy_after", 64'(busy), 64'd0);
    check("p3_valid_after", 64'(valid_out), 64'd0);
    check("p3_cnt", 64'(pkt_count), 64'd2);

    // Backpressure on the second flit for 5 cycles; req_valid asserted in PAYLOAD
    req_valid = 1'b1; req_dst_x = 4'd1; req_dst_y = 4'd0; req_len = 6'd3;
    data_valid = 1'b1; data_in = 62'hA;
    step();
    req_valid = 1'b0;
    #1;
    check("bp_head", flit_out, head(2'b01, 4'd1, 4'd0, 6'd3));
    step();
    ready_in = 1'b0; req_valid = 1'b1; data_in = 62'hB;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_flit", flit_out, {2'b00, 62'hA});
      check("bp_hold_valid", 64'(valid_out), 64'd1);
      check("bp_data_ready", 64'(data_ready), 64'd0);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    ready_in = 1'b1; req_valid = 1'b0;
    #1;
    check("bp_still_a", flit_out, {2'b00, 62'hA});
    check("bp_resume_ready", 64'(data_ready), 64'd1);
    step(); data_in = 62'hC; #1;
    check("bp_body_b", flit_out, {2'b00, 62'hB});
    step(); data_valid = 1'b0; #1;
    check("bp_tail_c", flit_out, {2'b10, 62'hC});
    step();
    check("bp_valid_after", 64'(valid_out), 64'd0);
    check("bp_cnt", 64'(pkt_count), 64'd3);

    // Back-to-back len=1 packets with req_valid held
    req_valid = 1'b1; req_dst_x = 4'd5; req_dst_y = 4'd6; req_len = 6'd1;
    data_valid = 1'b1; data_in = 62'h11;
    step(); #1;
    check("b2b_head1", flit_out, head(2'b01, 4'd5, 4'd6, 6'd1));
    step(); data_in = 62'h22; #1;
    check("b2b_tail1", flit_out, {2'b10, 62'h11});
    step(); req_valid = 1'b0; #1;
    check("b2b_head2", flit_out, head(2'b01, 4'd5, 4'd6, 6'd1));
    check("b2b_valid2", 64'(valid_out), 64'd1);
    step(); data_valid = 1'b0; #1;
    check("b2b_tail2", flit_out, {2'b10, 62'h22});
    step();
    check("b2b_valid_after", 64'(valid_out), 64'd0);
    check("b2b_cnt", 64'(pkt_count), 64'd5);

    // Maximum length: head plus 63 payload flits
    req_valid = 1'b1; req_dst_x = 4'd0; req_dst_y = 4'd15; req_len = 6'd63;
    data_valid = 1'b1; data_in = 62'd1;
    step(); req_valid = 1'b0; #1;
    check("max_head", flit_out, head(2'b01, 4'd0, 4'd15, 6'd63));
    for (int k = 1; k <= 63; k++) begin
      step();
      data_in = 62'(k + 1);
      #1;
      check("max_flit", flit_out, {(k == 63) ? 2'b10 : 2'b00, 62'(k)});
    end
    data_valid = 1'b0;
    #1;
    check("max_req_ready", 64'(req_ready), 64'd1);
    step();
    check("max_busy_after", 64'(busy), 64'd0);
    check("max_cnt", 64'(pkt_count), 64'd6);

    // Reset mid-packet after two payload flits, then a fresh single-flit packet
    req_valid = 1'b1; req_dst_x = 4'd7; req_dst_y = 4'd7; req_len = 6'd5;
    data_valid = 1'b1; data_in = 62'h31;
    step(); req_valid = 1'b0; #1;
    check("mr_head", flit_out, head(2'b01, 4'd7, 4'd7, 6'd5));
    step(); data_in = 62'h32; #1;
    check("mr_body1", flit_out, {2'b00, 62'h31});
    step(); #1;
    check("mr_body2", flit_out, {2'b00, 62'h32});
    rst_n = 1'b0;
    #1;
    check("mr_rst_req_ready", 64'(req_ready), 64'd0);
    check("mr_rst_data_ready", 64'(data_ready), 64'd0);
    step();
    check("mr_valid", 64'(valid_out), 64'd0);
    check("mr_flit", flit_out, 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_cnt", 64'(pkt_count), 64'd0);
    rst_n = 1'b1; data_valid = 1'b0;
    #1;
    check("mr_idle_req_ready", 64'(req_ready), 64'd1);
    check("mr_idle_data_ready", 64'(data_ready), 64'd0);
    req_valid = 1'b1; req_dst_x = 4'd4; req_dst_y = 4'd9; req_len = 6'd0;
    step(); req_valid = 1'b0; #1;
    check("mr_new_ht", flit_out, head(2'b11, 4'd4, 4'd9, 6'd0));
    check("mr_new_valid", 64'(valid_out), 64'd1);
    step();
    check("mr_new_cnt", 64'(pkt_count), 64'd1);
    check("mr_new_drained", 64'(valid_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
